// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes and bubbles for a 5-stage pipe,
// with saturating counters for stalled cycles and taken-branch flushes.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  Rs_id,
  input  logic [2:0]  Rt_id,
  input  logic        Rs_valid_id,
  input  logic        Rt_valid_id,
  input  logic [2:0]  Rd_id_ex,
  input  logic        Rd_valid_id_ex,
  input  logic        WriteReg_id_ex,
  input  logic        MemRead_id_ex,
  input  logic        branch_taken_ex,
  input  logic        halt_id,
  input  logic        mem_stall,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        ex_mem_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        id_ex_bubble,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles,
  output logic [7:0]  flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FLUSH    = 2'b10,
    HALTED   = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [7:0]  flush_count_q, flush_count_d;
  logic        load_use;
  logic        flush_event;

  assign load_use = MemRead_id_ex & WriteReg_id_ex & Rd_valid_id_ex &
                    ((Rs_valid_id & (Rs_id == Rd_id_ex)) |
                     (Rt_valid_id & (Rt_id == Rd_id_ex)));

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    flush_event  = 1'b0;
    state_d      = state_q;

    if (state_q == HALTED) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (mem_stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      state_d      = MEM_WAIT;
    end else if (branch_taken_ex) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      flush_event  = 1'b1;
      state_d      = FLUSH;
    end else if (load_use && state_q != FLUSH) begin
      // The load advances into MEM, so one bubble resolves the hazard.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      state_d      = RUN;
    end else if (halt_id && state_q != FLUSH) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      state_d      = HALTED;
    end else begin
      state_d      = RUN;
    end

    // Reset blanks all enables immediately, without waiting for an edge.
    if (!rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      id_ex_bubble = 1'b0;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!pc_write && state_q != HALTED && stall_cycles_q != 16'hFFFF)
      stall_cycles_d = stall_cycles_q + 16'd1;
    if (flush_event && flush_count_q != 8'hFF)
      flush_count_d = flush_count_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      stall_cycles_q <= 16'd0;
      flush_count_q  <= 8'd0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign state        = state_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with expected
// per-cycle results queued as stimulus is driven and popped when sampled.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [2:0] rs;
    logic [2:0] rt;
    logic       rs_v;
    logic       rt_v;
    logic [2:0] rd;
    logic       rd_v;
    logic       wr;
    logic       mr;
    logic       br;
    logic       halt;
    logic       ms;
  } stim_t;

  typedef struct packed {
    logic [6:0]  ctrl;
    logic [1:0]  st;
    logic [15:0] stalls;
    logic [7:0]  flushes;
  } exp_t;

  localparam logic [1:0] S_RUN = 2'b00, S_MW = 2'b01, S_FL = 2'b10, S_HA = 2'b11;
  // {pc, if_id_w, id_ex_w, ex_mem_w, if_id_flush, id_ex_flush, bubble}
  localparam logic [6:0] C_DEF = 7'b1111000;
  localparam logic [6:0] C_FRZ = 7'b0000000;
  localparam logic [6:0] C_BR  = 7'b1111110;
  localparam logic [6:0] C_LU  = 7'b0011001;
  localparam logic [6:0] C_HEN = 7'b0011000;
  localparam logic [6:0] C_HLT = 7'b0011001;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  Rs_id, Rt_id, Rd_id_ex;
  logic        Rs_valid_id, Rt_valid_id, Rd_valid_id_ex, WriteReg_id_ex, MemRead_id_ex;
  logic        branch_taken_ex, halt_id, mem_stall;
  logic        pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic        if_id_flush, id_ex_flush, id_ex_bubble;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0]  m_state;
  logic [15:0] m_stalls;
  logic [7:0]  m_flushes;
  exp_t        sb[$];

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .Rs_id(Rs_id), .Rt_id(Rt_id), .Rs_valid_id(Rs_valid_id), .Rt_valid_id(Rt_valid_id),
    .Rd_id_ex(Rd_id_ex), .Rd_valid_id_ex(Rd_valid_id_ex), .WriteReg_id_ex(WriteReg_id_ex),
    .MemRead_id_ex(MemRead_id_ex), .branch_taken_ex(branch_taken_ex), .halt_id(halt_id),
    .mem_stall(mem_stall), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .id_ex_bubble(id_ex_bubble), .state(state),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctrl_now();
    return {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, id_ex_bubble};
  endfunction

  task automatic drive(input stim_t s);
    Rs_id = s.rs; Rt_id = s.rt; Rs_valid_id = s.rs_v; Rt_valid_id = s.rt_v;
    Rd_id_ex = s.rd; Rd_valid_id_ex = s.rd_v; WriteReg_id_ex = s.wr; MemRead_id_ex = s.mr;
    branch_taken_ex = s.br; halt_id = s.halt; mem_stall = s.ms;
  endtask

  // Called at posedge+1: drive one cycle, compare at the falling edge, advance.
  task automatic step(input string tag, input stim_t s, input logic [6:0] exp_ctrl,
                      input logic [1:0] exp_next);
    exp_t e, got;
    drive(s);
    sb.push_back('{ctrl: exp_ctrl, st: m_state, stalls: m_stalls, flushes: m_flushes});
    #4;
    e = sb.pop_front();
    got = '{ctrl: ctrl_now(), st: state, stalls: stall_cycles, flushes: flush_count};
    if (got !== e) begin
      check({tag, ".ctrl"}, 32'(got.ctrl), 32'(e.ctrl));
      check({tag, ".state"}, 32'(got.st), 32'(e.st));
      check({tag, ".stalls"}, 32'(got.stalls), 32'(e.stalls));
      check({tag, ".flushes"}, 32'(got.flushes), 32'(e.flushes));
    end else begin
      check(tag, 32'(got), 32'(e));
    end
    if (!exp_ctrl[6] && m_state != S_HA && m_stalls != 16'hFFFF) m_stalls++;
    if (exp_ctrl[2] && m_flushes != 8'hFF) m_flushes++;
    m_state = exp_next;
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges with hostile inputs; everything must clear at once.
  task automatic do_reset(input string tag);
    stim_t s;
    s = '0;
    s.br = 1'b1; s.halt = 1'b1; s.ms = 1'b1;
    drive(s);
    rst = 1'b0;
    #1;
    check({tag, ".ctrl"}, 32'(ctrl_now()), 32'd0);
    check({tag, ".state"}, 32'(state), 32'(S_RUN));
    check({tag, ".stalls"}, 32'(stall_cycles), 32'd0);
    check({tag, ".flushes"}, 32'(flush_count), 32'd0);
    drive('0);
    #1;
    rst = 1'b1;
    m_state = S_RUN; m_stalls = '0; m_flushes = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    stim_t idle, lu, br, ms, ms_br, hlt;
    idle = '0;
    lu = '0; lu.rs = 3'd3; lu.rs_v = 1'b1; lu.rd = 3'd3; lu.rd_v = 1'b1; lu.wr = 1'b1; lu.mr = 1'b1;
    br = '0; br.br = 1'b1;
    ms = '0; ms.ms = 1'b1;
    ms_br = ms; ms_br.br = 1'b1;
    hlt = '0; hlt.halt = 1'b1;

    do_reset("reset0");

    // Load-use through Rs, then through Rt, then a non-matching register.
    step("lu_rs", lu, C_LU, S_RUN);
    step("lu_after", idle, C_DEF, S_RUN);
    begin
      stim_t t;
      t = lu; t.rs_v = 1'b0; t.rt = 3'd3; t.rt_v = 1'b1;
      step("lu_rt", t, C_LU, S_RUN);
      t = lu; t.rs = 3'd4;
      step("lu_nomatch", t, C_DEF, S_RUN);
      t = lu; t.mr = 1'b0;
      step("lu_nomemread", t, C_DEF, S_RUN);
    end

    // Branch, then a load-use pattern inside FLUSH is ignored.
    do_reset("reset_br");
    step("br", br, C_BR, S_FL);
    step("br_flush_lu", lu, C_DEF, S_RUN);
    step("br_after", idle, C_DEF, S_RUN);
    step("br_halt_prio", (br | hlt), C_BR, S_FL);
    step("flush_halt_ign", hlt, C_DEF, S_RUN);

    // Memory freeze swallowing a branch, then the branch re-presented.
    do_reset("reset_frz");
    step("frz1", ms_br, C_FRZ, S_MW);
    step("frz2", ms, C_FRZ, S_MW);
    step("frz3", ms, C_FRZ, S_MW);
    step("frz_rebr", br, C_BR, S_FL);
    step("frz_end", idle, C_DEF, S_RUN);
    step("frz_ms_lu", (ms | lu), C_FRZ, S_MW);
    step("mw_lu", lu, C_LU, S_RUN);
    step("mw_lu_after", idle, C_DEF, S_RUN);

    // Halt: only reset leaves HALTED; stall counter frozen.
    do_reset("reset_halt");
    step("halt_entry", hlt, C_HEN, S_HA);
    step("halted_ms_br", ms_br, C_HLT, S_HA);
    step("halted_idle", idle, C_HLT, S_HA);

    // Async reset in the middle of MEM_WAIT.
    do_reset("reset_pre_mw");
    step("mw1", ms, C_FRZ, S_MW);
    step("mw2", ms, C_FRZ, S_MW);
    do_reset("reset_mid_mw");
    step("post_reset", idle, C_DEF, S_RUN);

    // Saturating counters.
    do_reset("reset_sat_s");
    for (int i = 0; i < 65540; i++) step("sat_stall", ms, C_FRZ, S_MW);
    step("sat_stall_end", idle, C_DEF, S_RUN);
    check("sat_stall_model", 32'(m_stalls), 32'hFFFF);
    do_reset("reset_sat_f");
    for (int i = 0; i < 260; i++) step("sat_flush", br, C_BR, S_FL);
    step("sat_flush_end", idle, C_DEF, S_RUN);
    check("sat_flush_model", 32'(m_flushes), 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 Rs_id, Rt_id  in  3 each  ID-stage source registers; Rs_valid_id, Rt_valid_id  in  1 each  source-used flags.
REQ-005 Rd_id_ex  in  3  EX-stage destination; Rd_valid_id_ex, WriteReg_id_ex, MemRead_id_ex  in  1 each  EX-stage qualifiers.
REQ-006 branch_taken_ex  in  1  branch/jump in EX resolved taken this cycle.
REQ-007 halt_id  in  1  HALT decoded in ID.
REQ-008 mem_stall  in  1  data memory busy.
REQ-009 pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  pipeline register enables.
REQ-010 if_id_flush, id_ex_flush  out  1 each  load a NOP into the register at the next edge.
REQ-011 id_ex_bubble  out  1  load a NOP into ID/EX while IF/ID holds.
REQ-012 state  out  2  current FSM state.
REQ-013 stall_cycles  out  16  saturating count of stalled cycles.
REQ-014 flush_count  out  8  saturating count of taken-branch flushes.

Function
REQ-015 FSM encoding SHALL be RUN=00, MEM_WAIT=01, FLUSH=10, HALTED=11; state SHALL be registered; all control outputs SHALL be combinational from state and current inputs.
REQ-016 Default outputs SHALL be: all four write enables 1, flushes 0, bubble 0.
REQ-017 load_use SHALL be MemRead_id_ex & WriteReg_id_ex & Rd_valid_id_ex & ((Rs_valid_id & Rs_id==Rd_id_ex) | (Rt_valid_id & Rt_id==Rd_id_ex)).
REQ-018 Event priority in RUN and FLUSH SHALL be: mem_stall > branch_taken_ex > load_use > halt_id.
REQ-019 mem_stall=1, any state except HALTED: all write enables 0, no flush, no bubble; next state MEM_WAIT.
REQ-020 MEM_WAIT: outputs as REQ-019 while mem_stall=1; when mem_stall=0, the cycle is treated as RUN with events evaluated per REQ-018.
REQ-021 branch_taken_ex=1, no mem_stall: pc_write=1, if_id_flush=1, id_ex_flush=1, id_ex_bubble=0; flush_count increments (saturates at 8'hFF); next state FLUSH.
REQ-022 FLUSH SHALL last exactly one cycle; load_use and halt_id SHALL be ignored in it (ID holds a flushed NOP); mem_stall and branch_taken_ex are honoured; default next state RUN.
REQ-023 load_use in RUN, no higher event: pc_write=0, if_id_write=0, id_ex_bubble=1, ex_mem_write=1; state stays RUN; stall lasts exactly one cycle because the load advances.
REQ-024 halt_id in RUN, no higher event: pc_write=0, if_id_write=0, id_ex_write=1 (HALT enters EX); next state HALTED.
REQ-025 HALTED: pc_write=0, if_id_write=0, id_ex_bubble=1, ex_mem_write=1; mem_stall is ignored; exit only by reset.
REQ-026 stall_cycles SHALL increment on every cycle with pc_write=0 and state!=HALTED at that edge (covers load-use, MEM_WAIT, the halt-entry cycle), saturating at 16'hFFFF.
REQ-027 mem_stall and branch_taken_ex in the same cycle: mem_stall wins, branch is not counted; the branch is re-presented by EX once the freeze ends.

Reset
REQ-028 While rst=0: state=RUN, stall_cycles=0, flush_count=0; pc_write, if_id_write, id_ex_write, ex_mem_write, flushes and bubble SHALL be 0.
REQ-029 Reset assertion mid-stall, mid-flush or in HALTED SHALL take effect immediately without a clock edge; the first edge after deassertion evaluates from RUN.

Verification
REQ-030 Load-use: EX lw Rd=3 (MemRead=1, WriteReg=1), ID Rs_id=3 Rs_valid=1 -> one cycle pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cycles 0->1; next cycle defaults.
REQ-031 Branch: branch_taken_ex=1 in RUN -> if_id_flush=id_ex_flush=1, state=10 next cycle; a load_use pattern in that FLUSH cycle gives no stall; flush_count=1.
REQ-032 Mem freeze: mem_stall=1 for 3 cycles with branch_taken_ex=1 in cycle 1 -> all enables 0 for 3 cycles, state=01, flush_count=0, stall_cycles=3.
REQ-033 Halt: halt_id=1 in RUN -> pc_write=0, state=11 next; then mem_stall=1 and branch_taken_ex=1 change nothing; stall_cycles stops at 1.
REQ-034 Saturation: hold mem_stall=1 for 65540 cycles -> stall_cycles=16'hFFFF; force 260 branches -> flush_count=8'hFF.
REQ-035 Async reset: drop rst mid-MEM_WAIT between edges -> outputs and counters clear immediately; release -> state=RUN.
